dac_con_mc: RTL and testbench
=============================

# dac_con_mc

Parametrised multi-channel synchronous DAC controller: the next generation of the 12-bit-internal / 8-bit-output DAC controller. It holds an IN_W-bit raw code per channel, taken from a streamed sample input or from an on-chip sawtooth/triangle generator. On each update tick it reduces the raw code to OUT_W bits with first-order error-feedback noise shaping. It sits between the sample source (DSP/CPU stream) and the parallel DAC pins, all on clk_fast.

## Interface
- IN_W, 12, internal code width
- OUT_W, 8, DAC output width; legal range 1..IN_W-1
- NCH, 2, number of channels
- DIV_W, 8, width of update-period divisor
- CH_W, $clog2(NCH) (min 1), channel index width (derived)

Ports:
- clk_fast  in  1  single clock
- rst_n  in  1  reset; one clock, reset is synchronous and active-low
- mode  in  2*NCH  per-channel mode, ch k at [2k+1:2k]: 00 HOLD, 01 STREAM, 10 SAW, 11 TRI
- div  in  DIV_W  update period = div+1 cycles
- step  in  IN_W  ramp increment, shared by all channels
- s_data  in  IN_W  sample
- s_ch  in  CH_W  target channel of s_data
- s_valid  in  1  sample valid
- s_ready  out  1  = !pending[s_ch]; forced 0 while rst_n=0
- clr_underrun  in  1  clears all underrun bits
- dac_tick  out  1  one-cycle pulse, coincident with new dac_out/raw_out
- dac_out  out  OUT_W*NCH  shaped codes, ch k at [OUT_W*(k+1)-1:OUT_W*k]
- raw_out  out  IN_W*NCH  current raw codes
- underrun  out  NCH  sticky per-channel underrun flags

## Operation
- Divider: cnt counts up each cycle. The tick condition is cnt >= div; cnt then returns to 0. div=0 gives a tick every cycle. When div is lowered below cnt, the tick fires on the next cycle.
- Input: per-channel 1-entry pending buffer. Accept when s_valid && s_ready; data goes to pend[s_ch].
- The following happen on a tick, per channel, according to mode:
  - HOLD: raw unchanged. Pending is neither consumed nor cleared.
  - STREAM: if pending is full, raw <= pend and pending is cleared. If pending is empty, raw is unchanged and underrun[k] is set.
  - SAW: raw <= (raw + step) mod 2^IN_W.
  - TRI: with dir=up, if raw+step > 2^IN_W-1, raw <= 2^IN_W-1 and dir <= down; otherwise raw += step. With dir=down, if raw < step, raw <= 0 and dir <= up; otherwise raw -= step.
- Shaping (every tick, all modes, using the new raw):
  - sum = {0,raw} + err, IN_W+1 bits, where err holds IN_W-OUT_W bits.
  - If sum[IN_W]=1: dac <= all ones, err <= 0.
  - Otherwise: dac <= sum[IN_W-1:IN_W-OUT_W], err <= sum[IN_W-OUT_W-1:0].
- Mode changes take effect at the next tick. Ramps start from the current raw; dir and err are retained.
- Accept and tick on the same channel in the same cycle: the tick sees the pre-accept pending state. The new sample stays in pending for the next tick. If pending was empty, underrun is set at this tick.
- clr_underrun has priority below a same-cycle set; the set wins.
- step=0: SAW/TRI hold raw. TRI with step=0 never flips dir.

## Timing
- Reset (rst_n=0 at an edge) drives: cnt=0, all raw=0, err=0, dac_out=0, raw_out=0, dac_tick=0, underrun=0, pending empty, dir=up.
- Reset mid-operation discards pending samples. The first tick occurs div+1 cycles after rst_n rises.
- Tick condition at cycle T → raw_out, dac_out and dac_tick all registered, valid in T+1. dac_tick stays high for exactly one cycle.
- s_ready is combinational from pending and s_ch; there is no combinational path from s_valid.
- Input-to-output latency (STREAM): a sample accepted in cycle A appears at the first tick with T > A, visible in T+1.
- All outputs are registered except s_ready.

## Test plan
- Reset/divider: div=3, all HOLD → outputs 0, dac_tick every 4th cycle. Assert rst_n low mid-count → outputs cleared, next tick 4 cycles after release.
- Stream handshake: ch0 STREAM, push 0x123 then 0x456 before a tick → 2nd push sees s_ready=0. Tick → raw_out ch0=0x123, s_ready returns to 1. No push before the next tick → underrun[0]=1. clr_underrun → 0.
- Noise shaping: IN_W=12, OUT_W=8, STREAM raw=0x808, div=0 → dac_out alternates 0x80, 0x81; mean 0x80.8.
- Saturation: raw=0xFFF → dac_out 0xFF on every tick (err 0xF, then overflow clears it); never wraps to 0x00.
- SAW wrap: start raw=0xFF0, step=0x020 → 0x010 on next tick. TRI: raw=0xFF0, step=0x020 → 0xFFF, then 0xFDF, 0xFBF. Descending raw=0x010 → 0x000, then 0x020.
- Simultaneous accept+tick: ch1 pending empty, push on tick cycle → underrun[1]=1, raw unchanged. Next tick loads the sample.

Source files
------------

// File: rtl/dac_con_mc.sv
// Multi-channel DAC controller: shared update divider, per-channel raw code
// source (stream / sawtooth / triangle) and first-order error-feedback
// reduction from IN_W to OUT_W bits.

module dac_con_mc_ch #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 8
) (
  input  logic              clk_fast,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [1:0]        mode,
  input  logic [IN_W-1:0]   step,
  input  logic              wr,
  input  logic [IN_W-1:0]   wdata,
  input  logic              clr,
  output logic              pending,
  output logic [IN_W-1:0]   raw,
  output logic [OUT_W-1:0]  dac,
  output logic              underrun
);
  localparam int E = IN_W - OUT_W;
  localparam logic [1:0] M_HOLD = 2'b00, M_STREAM = 2'b01, M_SAW = 2'b10, M_TRI = 2'b11;

  logic [IN_W-1:0]  pend_d;
  logic [E-1:0]     err;
  logic             dir_dn;

  logic [IN_W-1:0]  raw_n;
  logic             dir_n;
  logic             take;
  logic             miss;
  logic [IN_W:0]    sum_up;
  logic [IN_W:0]    sum;
  logic [OUT_W-1:0] dac_n;
  logic [E-1:0]     err_n;

  // Next raw code per mode, then shape the new raw with the carried error.
  always_comb begin
    raw_n  = raw;
    dir_n  = dir_dn;
    take   = 1'b0;
    miss   = 1'b0;
    sum_up = {1'b0, raw} + {1'b0, step};
    case (mode)
      M_STREAM: begin
        if (pending) begin
          raw_n = pend_d;
          take  = 1'b1;
        end else begin
          miss  = 1'b1;
        end
      end
      M_SAW: raw_n = sum_up[IN_W-1:0];
      M_TRI: begin
        if (!dir_dn) begin
          if (sum_up[IN_W]) begin
            raw_n = {IN_W{1'b1}};
            dir_n = 1'b1;
          end else begin
            raw_n = sum_up[IN_W-1:0];
          end
        end else begin
          if (raw < step) begin
            raw_n = '0;
            dir_n = 1'b0;
          end else begin
            raw_n = raw - step;
          end
        end
      end
      default: ;
    endcase
    sum = {1'b0, raw_n} + {{(OUT_W+1){1'b0}}, err};
    if (sum[IN_W]) begin
      dac_n = {OUT_W{1'b1}};
      err_n = '0;
    end else begin
      dac_n = sum[IN_W-1:E];
      err_n = sum[E-1:0];
    end
  end

  // Channel state; an accept only arrives when pending is empty, so it
  // never collides with a same-cycle consume.
  always_ff @(posedge clk_fast) begin
    if (!rst_n) begin
      raw      <= '0;
      dac      <= '0;
      err      <= '0;
      dir_dn   <= 1'b0;
      pending  <= 1'b0;
      pend_d   <= '0;
      underrun <= 1'b0;
    end else begin
      if (tick) begin
        raw    <= raw_n;
        dir_dn <= dir_n;
        dac    <= dac_n;
        err    <= err_n;
      end
      if (wr) begin
        pending <= 1'b1;
        pend_d  <= wdata;
      end else if (tick && take) begin
        pending <= 1'b0;
      end
      if (tick && miss)  underrun <= 1'b1;
      else if (clr)      underrun <= 1'b0;
    end
  end
endmodule

module dac_con_mc #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 8,
  parameter int NCH   = 2,
  parameter int DIV_W = 8,
  parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk_fast,
  input  logic                  rst_n,
  input  logic [2*NCH-1:0]      mode,
  input  logic [DIV_W-1:0]      div,
  input  logic [IN_W-1:0]       step,
  input  logic [IN_W-1:0]       s_data,
  input  logic [CH_W-1:0]       s_ch,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  clr_underrun,
  output logic                  dac_tick,
  output logic [OUT_W*NCH-1:0]  dac_out,
  output logic [IN_W*NCH-1:0]   raw_out,
  output logic [NCH-1:0]        underrun
);
  logic [DIV_W-1:0] cnt;
  logic             tick;
  logic [NCH-1:0]   pending;
  logic [NCH-1:0]   wr;
  logic             pend_sel;

  // >= rather than == so lowering div below cnt ticks on the next cycle.
  assign tick = (cnt >= div);

  // Update-period divider and registered tick strobe.
  always_ff @(posedge clk_fast) begin
    if (!rst_n) begin
      cnt      <= '0;
      dac_tick <= 1'b0;
    end else begin
      cnt      <= tick ? '0 : cnt + 1'b1;
      dac_tick <= tick;
    end
  end

  // Ready follows the addressed channel's pending bit; out-of-range
  // channel indices are never ready.
  always_comb begin
    pend_sel = 1'b1;
    for (int k = 0; k < NCH; k++)
      if (s_ch == CH_W'(k)) pend_sel = pending[k];
    s_ready = rst_n && !pend_sel;
    for (int k = 0; k < NCH; k++)
      wr[k] = s_valid && s_ready && (s_ch == CH_W'(k));
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    dac_con_mc_ch #(.IN_W(IN_W), .OUT_W(OUT_W)) u_ch (
      .clk_fast (clk_fast),
      .rst_n    (rst_n),
      .tick     (tick),
      .mode     (mode[2*k +: 2]),
      .step     (step),
      .wr       (wr[k]),
      .wdata    (s_data),
      .clr      (clr_underrun),
      .pending  (pending[k]),
      .raw      (raw_out[IN_W*k +: IN_W]),
      .dac      (dac_out[OUT_W*k +: OUT_W]),
      .underrun (underrun[k])
    );
  end
endmodule

// File: tb/tb_dac_con_mc.sv
// Bench for dac_con_mc: directed scenarios plus randomized traffic, all
// checked against an arithmetic reference model of the channel behaviour.
module tb_dac_con_mc;
  localparam int IN_W = 12, OUT_W = 8, NCH = 2, DIV_W = 8, CH_W = 1;
  localparam int E = IN_W - OUT_W;
  localparam int MAXV = (1 << IN_W) - 1;
  localparam int OW = 1 + OUT_W*NCH + IN_W*NCH + NCH;

  logic                 clk_fast = 0;
  logic                 rst_n = 0;
  logic [2*NCH-1:0]     mode = '0;
  logic [DIV_W-1:0]     div = '0;
  logic [IN_W-1:0]      step = '0;
  logic [IN_W-1:0]      s_data = '0;
  logic [CH_W-1:0]      s_ch = '0;
  logic                 s_valid = 0;
  logic                 s_ready;
  logic                 clr_underrun = 0;
  logic                 dac_tick;
  logic [OUT_W*NCH-1:0] dac_out;
  logic [IN_W*NCH-1:0]  raw_out;
  logic [NCH-1:0]       underrun;

  dac_con_mc #(.IN_W(IN_W), .OUT_W(OUT_W), .NCH(NCH), .DIV_W(DIV_W)) dut (
    .clk_fast(clk_fast), .rst_n(rst_n), .mode(mode), .div(div), .step(step),
    .s_data(s_data), .s_ch(s_ch), .s_valid(s_valid), .s_ready(s_ready),
    .clr_underrun(clr_underrun), .dac_tick(dac_tick), .dac_out(dac_out),
    .raw_out(raw_out), .underrun(underrun));

  initial forever #5 clk_fast = ~clk_fast;

  wire [OW-1:0] obs = {dac_tick, dac_out, raw_out, underrun};

  int vectors = 0, miscompares = 0;

  // reference model state
  int m_cnt, m_tick;
  int m_raw[NCH], m_err[NCH], m_dac[NCH], m_dn[NCH], m_und[NCH], m_pv[NCH], m_pd[NCH];
  logic rdy_seen, rdy_exp;

  function automatic logic [OW-1:0] exp_vec();
    logic [OUT_W*NCH-1:0] d;
    logic [IN_W*NCH-1:0]  r;
    logic [NCH-1:0]       u;
    for (int k = 0; k < NCH; k++) begin
      d[OUT_W*k +: OUT_W] = OUT_W'(m_dac[k]);
      r[IN_W*k +: IN_W]   = IN_W'(m_raw[k]);
      u[k]                = m_und[k][0];
    end
    return {m_tick[0], d, r, u};
  endfunction

  // One clock: sample ready, advance the model with the applied inputs,
  // then let the DUT take the same edge.
  task automatic cyc();
    int ch;
    bit acc, tk;
    @(negedge clk_fast);
    rdy_seen = s_ready;
    ch = int'(s_ch);
    rdy_exp = rst_n && (ch < NCH) && !m_pv[ch];
    acc = s_valid && rdy_exp;
    if (!rst_n) begin
      m_cnt = 0; m_tick = 0;
      for (int k = 0; k < NCH; k++) begin
        m_raw[k] = 0; m_err[k] = 0; m_dac[k] = 0; m_dn[k] = 0;
        m_und[k] = 0; m_pv[k] = 0; m_pd[k] = 0;
      end
    end else begin
      tk = (m_cnt >= int'(div));
      m_cnt = tk ? 0 : m_cnt + 1;
      m_tick = tk;
      for (int k = 0; k < NCH; k++) begin
        int md, sum;
        bit set;
        md = int'(mode[2*k +: 2]);
        set = tk && md == 1 && !m_pv[k];
        if (clr_underrun) m_und[k] = 0;
        if (set) m_und[k] = 1;
        if (tk) begin
          case (md)
            1: if (m_pv[k]) begin m_raw[k] = m_pd[k]; m_pv[k] = 0; end
            2: m_raw[k] = (m_raw[k] + int'(step)) % (MAXV + 1);
            3: if (!m_dn[k]) begin
                 if (m_raw[k] + int'(step) > MAXV) begin m_raw[k] = MAXV; m_dn[k] = 1; end
                 else m_raw[k] = m_raw[k] + int'(step);
               end else begin
                 if (m_raw[k] < int'(step)) begin m_raw[k] = 0; m_dn[k] = 0; end
                 else m_raw[k] = m_raw[k] - int'(step);
               end
            default: ;
          endcase
          sum = m_raw[k] + m_err[k];
          if (sum > MAXV) begin m_dac[k] = (1 << OUT_W) - 1; m_err[k] = 0; end
          else begin m_dac[k] = sum >> E; m_err[k] = sum % (1 << E); end
        end
      end
      if (acc) begin m_pv[ch] = 1; m_pd[ch] = int'(s_data); end
    end
    @(posedge clk_fast);
    #1;
  endtask

  task automatic run_to_tick(output int n);
    n = 0;
    do begin cyc(); n++; end while (!dac_tick && n < 64);
  endtask

  task automatic do_reset();
    rst_n = 0; s_valid = 0; clr_underrun = 0;
    cyc(); cyc();
    rst_n = 1;
  endtask

  task automatic load_raw(input int ch, input int val);
    int n;
    s_ch = CH_W'(ch); s_data = IN_W'(val); s_valid = 1;
    cyc();
    s_valid = 0;
    run_to_tick(n);
  endtask

  task automatic test_reset();
    rst_n = 0; s_valid = 1; s_ch = 0; mode = '1; div = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      vectors++;
      if (obs !== '0 || rdy_seen !== 1'b0) begin
        miscompares++;
        $display("FAIL reset outputs=%h ready=%b, want 0/0", obs, rdy_seen);
      end
    end
    s_valid = 0; mode = '0;
  endtask

  task automatic test_divider();
    int n;
    rst_n = 1; div = 3; mode = '0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      vectors++;
      if (obs !== exp_vec() || dac_tick !== (i % 4 == 3)) begin
        miscompares++;
        $display("FAIL divider cyc%0d got %h want %h tick_exp=%0d", i, obs, exp_vec(), i % 4 == 3);
      end
    end
    cyc(); cyc();
    rst_n = 0; cyc();
    vectors++;
    if (obs !== '0) begin miscompares++; $display("FAIL midreset got %h want 0", obs); end
    rst_n = 1;
    run_to_tick(n);
    vectors++;
    if (n != 4 || dac_tick !== 1'b1) begin
      miscompares++; $display("FAIL first_tick_after_reset got %0d cycles want 4", n);
    end
  endtask

  task automatic test_stream_handshake();
    int n;
    do_reset();
    div = 7; mode = 4'b0001;
    s_ch = 0; s_data = 12'h123; s_valid = 1; cyc();
    vectors++;
    if (rdy_seen !== 1'b1) begin miscompares++; $display("FAIL push1_ready got %b want 1", rdy_seen); end
    s_data = 12'h456; cyc();
    vectors++;
    if (rdy_seen !== 1'b0) begin miscompares++; $display("FAIL push2_ready got %b want 0", rdy_seen); end
    s_valid = 0;
    run_to_tick(n);
    vectors++;
    if (raw_out[11:0] !== 12'h123 || s_ready !== 1'b1 || obs !== exp_vec()) begin
      miscompares++; $display("FAIL stream_load raw=%h ready=%b want 123/1", raw_out[11:0], s_ready);
    end
    run_to_tick(n);
    vectors++;
    if (underrun !== 2'b01 || raw_out[11:0] !== 12'h123) begin
      miscompares++; $display("FAIL stream_underrun und=%b raw=%h want 01/123", underrun, raw_out[11:0]);
    end
    clr_underrun = 1; cyc(); clr_underrun = 0;
    vectors++;
    if (underrun !== 2'b00 || obs !== exp_vec()) begin
      miscompares++; $display("FAIL clr_underrun got %b want 00", underrun);
    end
  endtask

  task automatic test_noise_shaping();
    int n;
    logic [7:0] prev;
    do_reset();
    div = 0; mode = 4'b0001;
    load_raw(0, 'h808);
    mode = 4'b0000;
    vectors++;
    if (dac_out[7:0] !== 8'h80 || raw_out[11:0] !== 12'h808) begin
      miscompares++; $display("FAIL shape_load dac=%h raw=%h want 80/808", dac_out[7:0], raw_out[11:0]);
    end
    prev = dac_out[7:0];
    for (int i = 0; i < 8; i++) begin
      run_to_tick(n);
      vectors++;
      if (9'(dac_out[7:0]) + 9'(prev) !== 9'h101 || obs !== exp_vec()) begin
        miscompares++; $display("FAIL shape_alt%0d got %h after %h, want pair sum 101", i, dac_out[7:0], prev);
      end
      prev = dac_out[7:0];
    end
  endtask

  task automatic test_saturation();
    int n;
    do_reset();
    div = 1; mode = 4'b0001;
    load_raw(0, 'hFFF);
    mode = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (dac_out[7:0] !== 8'hFF || obs !== exp_vec()) begin
        miscompares++; $display("FAIL saturate%0d got %h want ff", i, dac_out[7:0]);
      end
      run_to_tick(n);
    end
  endtask

  task automatic test_ramps();
    int n;
    logic [11:0] tri_up[3] = '{12'hFFF, 12'hFDF, 12'hFBF};
    do_reset();
    div = 1; step = 12'h020; mode = 4'b0001;
    load_raw(0, 'hFF0);
    mode = 4'b0010;
    run_to_tick(n);
    vectors++;
    if (raw_out[11:0] !== 12'h010 || obs !== exp_vec()) begin
      miscompares++; $display("FAIL saw_wrap got %h want 010", raw_out[11:0]);
    end
    mode = 4'b0100;
    load_raw(1, 'hFF0);
    mode = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      run_to_tick(n);
      vectors++;
      if (raw_out[23:12] !== tri_up[i] || obs !== exp_vec()) begin
        miscompares++; $display("FAIL tri_top%0d got %h want %h", i, raw_out[23:12], tri_up[i]);
      end
    end
    mode = 4'b0100;
    load_raw(1, 'h010);
    mode = 4'b1100;
    run_to_tick(n);
    vectors++;
    if (raw_out[23:12] !== 12'h000) begin
      miscompares++; $display("FAIL tri_floor got %h want 000", raw_out[23:12]);
    end
    run_to_tick(n);
    vectors++;
    if (raw_out[23:12] !== 12'h020 || obs !== exp_vec()) begin
      miscompares++; $display("FAIL tri_rebound got %h want 020", raw_out[23:12]);
    end
  endtask

  task automatic test_accept_on_tick();
    int n;
    do_reset();
    div = 3; mode = 4'b0000;
    run_to_tick(n);
    mode = 4'b0100;
    cyc(); cyc(); cyc();
    s_ch = 1; s_data = 12'hABC; s_valid = 1;
    cyc();
    s_valid = 0;
    vectors++;
    if (dac_tick !== 1'b1 || underrun !== 2'b10 || raw_out[23:12] !== 12'h000) begin
      miscompares++; $display("FAIL same_cycle tick=%b und=%b raw=%h want 1/10/000", dac_tick, underrun, raw_out[23:12]);
    end
    run_to_tick(n);
    vectors++;
    if (raw_out[23:12] !== 12'hABC || obs !== exp_vec()) begin
      miscompares++; $display("FAIL same_cycle_next got %h want abc", raw_out[23:12]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) div = DIV_W'($urandom_range(0, 5));
      if ($urandom_range(0, 31) == 0) mode = 4'($urandom);
      if ($urandom_range(0, 63) == 0) step = ($urandom_range(0, 3) == 0) ? '0 : IN_W'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
      s_valid = $urandom_range(0, 1);
      s_ch = CH_W'($urandom_range(0, NCH-1));
      s_data = IN_W'($urandom);
      clr_underrun = ($urandom_range(0, 15) == 0);
      cyc();
      vectors++;
      if (obs !== exp_vec() || rdy_seen !== rdy_exp) begin
        miscompares++;
        $display("FAIL random%0d got %h rdy %b want %h rdy %b", i, obs, rdy_seen, exp_vec(), rdy_exp);
      end
    end
    rst_n = 1; s_valid = 0; clr_underrun = 0;
  endtask

  initial begin
    test_reset();
    test_divider();
    test_stream_handshake();
    test_noise_shaping();
    test_saturation();
    test_ramps();
    test_accept_on_tick();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
